// File: rtl/sys_timer_pkg.sv
// Shared constants for the memory-mapped countdown timer:
// register offsets, CTRL bit positions, mode and state encodings.
package sys_timer_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    localparam logic [1:0] TMR_ONESHOT = 2'b00;
    localparam logic [1:0] TMR_RELOAD  = 2'b01;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_LOAD = 2'd1,
        TMR_CNT  = 2'd2,
        TMR_INT  = 2'd3
    } tmr_state_e;

    // Modes 1x fall back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == TMR_RELOAD;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sys_timer_tick_gen.sv
// Count-tick prescaler: pulses tick once every PRESCALE cycles of run.
// Ports: clk, reset (async, active-low), clr, run in; tick out.
module timer_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] pcnt;

    assign tick = run && (pcnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (run) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/sys_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes.
// Ports: clk, reset (async low), addr/byteen/wdata bus in; rdata, irq out.
module sys_timer
    import sys_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tmr_state_e  state_q, state_d;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        flag_q;

    logic        hit, wr_ctrl, wr_preset;
    logic [1:0]  off;
    logic        tick;
    logic        load, dec, enter_int, end_oneshot, leave_reload;
    logic        addr_unused;

    assign addr_unused = ^addr[1:0];

    assign hit       = addr[31:4] == BASE_ADDR[31:4];
    assign off       = addr[3:2];
    assign wr_ctrl   = hit && (|byteen) && (off == TMR_CTRL);
    assign wr_preset = hit && (|byteen) && (off == TMR_PRESET);

    timer_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == TMR_LOAD),
        .run   (state_q == TMR_CNT),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= TMR_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        dec          = 1'b0;
        enter_int    = 1'b0;
        end_oneshot  = 1'b0;
        leave_reload = 1'b0;
        unique case (state_q)
            TMR_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = TMR_LOAD;
            end
            TMR_LOAD: begin
                load    = 1'b1;
                state_d = TMR_CNT;
            end
            TMR_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = TMR_IDLE;
                end else if (tick) begin
                    if (count_q == '0) begin
                        state_d   = TMR_INT;
                        enter_int = 1'b1;
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            TMR_INT: begin
                if (is_reload(ctrl_q[CTRL_MODE +: 2])) begin
                    state_d      = TMR_LOAD;
                    leave_reload = 1'b1;
                end else begin
                    state_d     = TMR_IDLE;
                    end_oneshot = 1'b1;
                end
            end
            default: state_d = TMR_IDLE;
        endcase
    end

    // A software CTRL write outranks the one-shot EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            if (wr_ctrl && byteen[0]) ctrl_q <= wdata[3:0];
            else if (end_oneshot)     ctrl_q[CTRL_EN] <= 1'b0;

            if (wr_preset) preset_q <= lane_merge(preset_q, wdata, byteen);

            if (load)     count_q <= preset_q;
            else if (dec) count_q <= count_q - 32'd1;

            if (enter_int)                    flag_q <= 1'b1;
            else if (wr_ctrl || leave_reload) flag_q <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                TMR_CTRL:   rdata = {28'b0, ctrl_q};
                TMR_PRESET: rdata = preset_q;
                TMR_COUNT:  rdata = count_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_sys_timer.sv
// Bench for sys_timer: timeline model on a PRESCALE=1 instance,
// literal checks there and on a PRESCALE=4 instance.
module tb_sys_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam longint PS = 1;

    logic        clk, rst_n;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  byteen;
    logic        irq;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  byteen_b;
    logic        irq_b;

    int checks   = 0;
    int failures = 0;

    sys_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
        .clk(clk), .reset(rst_n), .addr(addr), .byteen(byteen),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    sys_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(rst_n), .addr(addr_b), .byteen(byteen_b),
        .wdata(wdata_b), .rdata(rdata_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: registers plus a timeline. While running, COUNT is
    // L - elapsed/PS from the load cycle; INT lands at start+(L+1)*PS.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    logic        m_flag, m_run;
    longint      m_start, m_l, n;

    always @(posedge clk or negedge rst_n) begin
        longint cur, int_at;
        logic   set_flag;
        if (!rst_n) begin
            m_ctrl = '0; m_preset = '0; m_count = '0;
            m_flag = 0; m_run = 0; m_start = 0; m_l = 0; n = 0;
        end else begin
            cur = n;
            n = n + 1;
            set_flag = 0;
            if (!m_run) begin
                if (m_ctrl[0]) begin
                    m_run = 1;
                    m_start = n + 1;
                end
            end else if (cur == m_start - 1) begin
                m_l = longint'(m_preset);
                m_count = m_preset;
            end else begin
                int_at = m_start + (m_l + 1) * PS;
                if (cur == int_at) begin
                    if (m_ctrl[2:1] == 2'b01) begin
                        m_start = n + 1;
                        m_flag = 0;
                    end else begin
                        m_run = 0;
                        m_ctrl[0] = 0;
                    end
                end else if (!m_ctrl[0]) begin
                    m_run = 0;
                end else if (n == int_at) begin
                    set_flag = 1;
                end else begin
                    m_count = 32'(m_l - (n - m_start) / PS);
                end
            end
            if (addr[31:4] == BASE[31:4] && |byteen) begin
                if (addr[3:2] == 2'd0) begin
                    if (byteen[0]) m_ctrl = wdata[3:0];
                    m_flag = 0;
                end else if (addr[3:2] == 2'd1) begin
                    for (int i = 0; i < 4; i++)
                        if (byteen[i]) m_preset[8*i +: 8] = wdata[8*i +: 8];
                end
            end
            if (set_flag) m_flag = 1;
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd0:    return {28'h0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] er;
        er = exp_rdata(addr);
        checks++;
        if (rdata !== er) begin
            failures++;
            $display("FAIL model_rdata t=%0t addr=%h got=%h want=%h",
                     $time, addr, rdata, er);
        end
        checks++;
        if (irq !== (m_flag & m_ctrl[3])) begin
            failures++;
            $display("FAIL model_irq t=%0t got=%b want=%b",
                     $time, irq, m_flag & m_ctrl[3]);
        end
    end

    task automatic step(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        step();
        byteen = 4'h0;
    endtask

    task automatic wr_b(input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
        addr_b = a; byteen_b = be; wdata_b = d;
        step();
        byteen_b = 4'h0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
        addr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    initial begin
        rst_n = 0; addr = A_CTRL; byteen = 0; wdata = 0;
        addr_b = A_CNT; byteen_b = 0; wdata_b = 0;
        step(2);
        rd_chk("por_ctrl", A_CTRL, 32'h0);
        chk("por_irq", {31'b0, irq}, 32'h0);
        rst_n = 1;
        step();

        // Reset mid-count.
        wr(A_PRE, 4'hF, 32'd100);
        wr(A_CTRL, 4'hF, 32'h9);
        step(6);
        rst_n = 0;
        step(2);
        rst_n = 1;
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        step();
        rd_chk("rst_pre", A_PRE, 32'h0);
        step();
        rd_chk("rst_cnt", A_CNT, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        step(3);
        rd_chk("rst_idle", A_CNT, 32'h0);
        wr(A_CNT, 4'hF, 32'hFFFF_FFFF);
        rd_chk("cnt_ro", A_CNT, 32'h0);

        // One-shot, PRESET=3.
        wr(A_PRE, 4'hF, 32'd3);
        wr(A_CTRL, 4'hF, 32'h9);
        step(); rd_chk("os_t1", A_CNT, 32'd0);
        step(); rd_chk("os_t2", A_CNT, 32'd3);
        step(); rd_chk("os_t3", A_CNT, 32'd2);
        step(); rd_chk("os_t4", A_CNT, 32'd1);
        step(); rd_chk("os_t5", A_CNT, 32'd0);
        chk("os_irq5", {31'b0, irq}, 32'h0);
        step(); chk("os_irq6", {31'b0, irq}, 32'h1);
        step(); rd_chk("os_en0", A_CTRL, 32'h8);
        step(3); chk("os_level", {31'b0, irq}, 32'h1);
        wr(A_CTRL, 4'hF, 32'h8);
        chk("os_clr", {31'b0, irq}, 32'h0);

        // Auto-reload, PRESET=2.
        wr(A_PRE, 4'hF, 32'd2);
        wr(A_CTRL, 4'hF, 32'hB);
        addr = A_CNT;
        step(5); chk("ar_p1", {31'b0, irq}, 32'h1);
        step();  chk("ar_low", {31'b0, irq}, 32'h0);
        step(4); chk("ar_p2", {31'b0, irq}, 32'h1);
        step();  chk("ar_low2", {31'b0, irq}, 32'h0);
        step();  rd_chk("ar_reload", A_CNT, 32'd2);
        step(9);
        wr(A_CTRL, 4'hF, 32'h0);
        step(8);

        // Byte lanes, mask, PRESET=0.
        wr(A_PRE, 4'hF, 32'h1111_1111);
        wr(A_PRE, 4'b0010, 32'h0000_AB00);
        rd_chk("lane", A_PRE, 32'h1111_AB11);
        wr(A_PRE, 4'hF, 32'h0);
        wr(A_CTRL, 4'hF, 32'h1);
        step(3);
        chk("mask_irq", {31'b0, irq}, 32'h0);
        step(2);
        rd_chk("mask_en0", A_CTRL, 32'h0);
        wr(A_CTRL, 4'b1110, 32'hFFFF_FFFF);
        rd_chk("hi_lanes", A_CTRL, 32'h0);
        wr(A_CTRL, 4'hF, 32'h8);
        chk("flag_gone", {31'b0, irq}, 32'h0);
        wr(A_CTRL, 4'hF, 32'h0);

        // CTRL write colliding with INT.
        wr(A_PRE, 4'hF, 32'd1);
        wr(A_CTRL, 4'hF, 32'h9);
        step(4);
        chk("col_int", {31'b0, irq}, 32'h1);
        wr(A_CTRL, 4'hF, 32'h9);
        rd_chk("col_en", A_CTRL, 32'h9);
        chk("col_irq", {31'b0, irq}, 32'h0);
        step(2);
        rd_chk("col_load", A_CNT, 32'd1);
        step(3);
        wr(A_CTRL, 4'hF, 32'h0);

        // Address miss.
        wr(BASE + 32'h10, 4'hF, 32'hFFFF_FFFF);
        rd_chk("miss_rd", BASE + 32'h10, 32'h0);
        step();
        rd_chk("miss_ctrl", A_CTRL, 32'h0);
        step();
        rd_chk("miss_pre", A_PRE, 32'd1);

        // Prescale 4 on the second instance.
        wr_b(A_PRE, 4'hF, 32'd1);
        wr_b(A_CTRL, 4'hF, 32'h9);
        addr_b = A_CNT;
        step(5); #1; chk("ps_c5", rdata_b, 32'd1);
        step();  #1; chk("ps_c6", rdata_b, 32'd0);
        step(3); chk("ps_irq9", {31'b0, irq_b}, 32'h0);
        step();  chk("ps_irq10", {31'b0, irq_b}, 32'h1);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
